// File: rtl/display_scheduler_if.sv
// display_scheduler_if: request/snapshot bus between the value sources, the scheduler and decodeshift.
interface display_scheduler_if #(parameter int DATA_W = 32);
  logic              enable;
  logic              req_a;
  logic              req_b;
  logic [DATA_W-1:0] src_a_data;
  logic [DATA_W-1:0] src_b_data;
  logic [DATA_W-1:0] cnt_out;
  logic              trigger;
  logic              ack_a;
  logic              ack_b;
  logic              grant_src;
  logic              busy;
  modport master (
    output enable, req_a, req_b, src_a_data, src_b_data,
    input  cnt_out, trigger, ack_a, ack_b, grant_src, busy
  );
  modport slave (
    input  enable, req_a, req_b, src_a_data, src_b_data,
    output cnt_out, trigger, ack_a, ack_b, grant_src, busy
  );
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: arbitrates two value sources plus a periodic refresh onto decodeshift, one frame at a time.
module display_scheduler #(
  parameter int DATA_W       = 32,
  parameter int SHIFT_CYCLES = 50,
  parameter int REFRESH_DIV  = 1000
) (
  input logic                clk,
  input logic                reset,
  display_scheduler_if.slave bus
);
  localparam int WW = $clog2(SHIFT_CYCLES);
  localparam int RW = $clog2(REFRESH_DIV);
  typedef enum logic [1:0] {IDLE, TRIG, WAIT} state_t;
  state_t            state_q, state_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [RW-1:0]     tmr_q, tmr_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              pa_q, pa_d, pb_q, pb_d, pr_q, pr_d;
  logic              grant_q, grant_d, last_q, last_d;
  logic              acka_q, acka_d, ackb_q, ackb_d;
  logic              start, sel, serve_a, serve_b, wrap;
  always_comb begin
    start   = state_q == IDLE && bus.enable && (pa_q || pb_q || pr_q);
    // a refresh with nothing pending re-sends whatever source was shown last
    sel     = (pa_q && pb_q) ? ~last_q : pa_q ? 1'b0 : pb_q ? 1'b1 : grant_q;
    serve_a = start && pa_q && !sel;
    serve_b = start && pb_q && sel;
    wrap    = tmr_q == RW'(REFRESH_DIV - 1);
    state_d = start ? TRIG :
              state_q == TRIG ? WAIT :
              (state_q == WAIT && wait_q == '0) ? IDLE : state_q;
    wait_d  = state_q == TRIG ? WW'(SHIFT_CYCLES - 1) :
              (state_q == WAIT && wait_q != '0) ? wait_q - 1'b1 : wait_q;
    tmr_d   = (start || wrap) ? '0 : tmr_q + 1'b1;
    pr_d    = !start && (pr_q || wrap);
    pa_d    = bus.req_a || (pa_q && !serve_a);
    pb_d    = bus.req_b || (pb_q && !serve_b);
    cnt_d   = start ? (sel ? bus.src_b_data : bus.src_a_data) : cnt_q;
    grant_d = start ? sel : grant_q;
    last_d  = start ? sel : last_q;
    acka_d  = serve_a;
    ackb_d  = serve_b;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      pr_q    <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      acka_q  <= 1'b0;
      ackb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pr_q    <= pr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      acka_q  <= acka_d;
      ackb_q  <= ackb_d;
    end
  end
  assign bus.cnt_out   = cnt_q;
  assign bus.trigger   = state_q == TRIG;
  assign bus.ack_a     = acka_q;
  assign bus.ack_b     = ackb_q;
  assign bus.grant_src = grant_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed scenarios with a cycle-level reference model checked every cycle.
module tb_display_scheduler;
  localparam int SHIFT = 50;
  localparam int DIV   = 200;
  logic clk, reset;
  int checks = 0, errors = 0, cyc = 0;
  display_scheduler_if #(.DATA_W(32)) bus ();
  display_scheduler #(.DATA_W(32), .SHIFT_CYCLES(SHIFT), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask
  // reference: busy is a countdown of remaining frame cycles, pending requests are plain flags
  int m_left, m_tmr;
  bit m_pa, m_pb, m_pr, m_grant, m_last, m_trig, m_acka, m_ackb, m_valid = 0;
  logic [31:0] m_cnt;
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_left = 0; m_tmr = 0; m_pa = 0; m_pb = 0; m_pr = 0;
      m_grant = 0; m_last = 1; m_trig = 0; m_acka = 0; m_ackb = 0;
      m_cnt = 0; m_valid = 1;
    end else begin
      bit go, src, wrap;
      go   = m_left == 0 && bus.enable && (m_pa || m_pb || m_pr);
      src  = (m_pa && m_pb) ? !m_last : m_pa ? 1'b0 : m_pb ? 1'b1 : m_grant;
      wrap = m_tmr == DIV - 1;
      m_trig = go;
      m_acka = go && m_pa && !src;
      m_ackb = go && m_pb && src;
      if (go) begin
        m_cnt = src ? bus.src_b_data : bus.src_a_data;
        m_grant = src; m_last = src;
        m_left = SHIFT + 1; m_tmr = 0; m_pr = 0;
      end else begin
        if (m_left > 0) m_left--;
        m_tmr = wrap ? 0 : m_tmr + 1;
        if (wrap) m_pr = 1;
      end
      m_pa = bus.req_a || (m_pa && !m_acka);
      m_pb = bus.req_b || (m_pb && !m_ackb);
    end
    #1;
    if (m_valid) begin
      chk("cyc_trigger", bus.trigger, m_trig);
      chk("cyc_ack_a", bus.ack_a, m_acka);
      chk("cyc_ack_b", bus.ack_b, m_ackb);
      chk("cyc_busy", bus.busy, m_left > 0);
      chk("cyc_cnt_out", bus.cnt_out, m_cnt);
      chk("cyc_grant_src", bus.grant_src, m_grant);
    end
  end
  task automatic wait_trig(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.trigger && n < 300);
    if (!bus.trigger) chk("wait_trig_timeout", 0, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("wait_idle_timeout", 1, 0);
  endtask
  task automatic pulse(input bit a, input bit b);
    bus.req_a = a;
    bus.req_b = b;
    @(negedge clk);
    bus.req_a = 0;
    bus.req_b = 0;
  endtask
  initial begin
    int n, t0;
    reset = 0; bus.enable = 1; bus.req_a = 0; bus.req_b = 0;
    bus.src_a_data = 32'hA5A5; bus.src_b_data = 32'hB6B6;
    repeat (3) @(negedge clk);
    chk("rst_trigger", bus.trigger, 0);
    chk("rst_ack_a", bus.ack_a, 0);
    chk("rst_ack_b", bus.ack_b, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt_out", bus.cnt_out, 0);
    reset = 1;
    wait_trig(n);
    chk("refresh_delay_in_range", n >= 200 && n <= 202, 1);
    chk("refresh_ack_a", bus.ack_a, 0);
    chk("refresh_ack_b", bus.ack_b, 0);
    chk("refresh_cnt_out", bus.cnt_out, 32'hA5A5);
    wait_idle();
    bus.src_a_data = 32'h654321;
    pulse(1, 0);
    chk("a_not_yet", bus.trigger, 0);
    @(negedge clk);
    chk("a_trigger", bus.trigger, 1);
    chk("a_ack_a", bus.ack_a, 1);
    chk("a_ack_b", bus.ack_b, 0);
    chk("a_cnt_out", bus.cnt_out, 32'h654321);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
      if (n == 1) chk("a_trigger_one_cycle", bus.trigger, 0);
    end
    chk("a_busy_len", n, 51);
    // req_a held across the serving edge, req_b during WAIT
    bus.src_a_data = 32'h33; bus.src_b_data = 32'h44;
    bus.req_a = 1;
    @(negedge clk);
    @(negedge clk);
    bus.req_a = 0;
    chk("rr_a1_trigger", bus.trigger, 1);
    chk("rr_a1_ack_a", bus.ack_a, 1);
    t0 = cyc;
    repeat (10) @(negedge clk);
    pulse(0, 1);
    chk("wait_no_trigger", bus.trigger, 0);
    wait_trig(n);
    chk("rr_b_spacing", cyc - t0, 52);
    chk("rr_b_cnt_out", bus.cnt_out, 32'h44);
    chk("rr_b_ack_b", bus.ack_b, 1);
    t0 = cyc;
    wait_trig(n);
    chk("rr_a2_spacing", cyc - t0, 52);
    chk("rr_a2_cnt_out", bus.cnt_out, 32'h33);
    chk("rr_a2_ack_a", bus.ack_a, 1);
    wait_idle();
    bus.src_b_data = 32'h55;
    pulse(0, 1);
    wait_trig(n);
    chk("b_cnt_out", bus.cnt_out, 32'h55);
    chk("b_grant_src", bus.grant_src, 1);
    wait_idle();
    bus.src_a_data = 32'h11; bus.src_b_data = 32'h22;
    pulse(1, 1);
    wait_trig(n);
    chk("tie1_cnt_out", bus.cnt_out, 32'h11);
    chk("tie1_ack_a", bus.ack_a, 1);
    chk("tie1_ack_b", bus.ack_b, 0);
    t0 = cyc;
    wait_trig(n);
    chk("tie1_b_spacing", cyc - t0, 52);
    chk("tie1_b_cnt_out", bus.cnt_out, 32'h22);
    chk("tie1_b_grant_src", bus.grant_src, 1);
    wait_idle();
    pulse(1, 1);
    wait_trig(n);
    chk("tie2_cnt_out", bus.cnt_out, 32'h11);
    wait_trig(n);
    chk("tie2_b_cnt_out", bus.cnt_out, 32'h22);
    wait_idle();
    // reset pulse mid-WAIT with B pending
    bus.src_a_data = 32'h77;
    pulse(1, 0);
    @(negedge clk);
    chk("pre_reset_trigger", bus.trigger, 1);
    repeat (10) @(negedge clk);
    pulse(0, 1);
    repeat (5) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_cnt_out", bus.cnt_out, 0);
    chk("midreset_trigger", bus.trigger, 0);
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (bus.trigger || bus.ack_b) n++;
    end
    chk("midreset_b_discarded", n, 0);
    bus.enable = 0;
    pulse(1, 0);
    n = 0;
    repeat (500) begin
      @(negedge clk);
      if (bus.trigger) n++;
    end
    chk("disabled_no_trigger", n, 0);
    bus.enable = 1;
    @(negedge clk);
    chk("enable_trigger", bus.trigger, 1);
    chk("enable_ack_a", bus.ack_a, 1);
    chk("enable_cnt_out", bus.cnt_out, 32'h77);
    wait_idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
